// File: rtl/rx_page_ctrl.sv
// Receive page scheduler: hands rx_bytes a free RAM page and queues completed
// pages, with their flags, for the host in arrival order.

module rx_page_slot (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       we,
   input  logic [7:0] d,
   output logic [7:0] q
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (we)  q <= d;
endmodule

module rx_page_ctrl #(
   parameter int PAGES = 4,
   parameter int PW    = $clog2(PAGES)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          switch,
   input  logic [7:0]    wr_flags,
   input  logic          rx_error,
   output logic          rx_abort,
   output logic [PW-1:0] wr_page,
   output logic          rx_pend,
   output logic [PW-1:0] rd_page,
   output logic [7:0]    rd_flags,
   input  logic          rd_release,
   input  logic          rx_clear,
   output logic [PW:0]   pend_cnt,
   output logic [7:0]    lost_cnt,
   output logic [7:0]    err_cnt,
   input  logic          cnt_clr
);
   // One page is always reserved for rx_bytes, so the queue holds PAGES-1.
   localparam logic [PW:0] CNT_FULL = (PW+1)'(PAGES - 1);

   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [PW:0]             count, cnt_rel;
   logic [PAGES-1:0][7:0]   flags;
   logic                    rel_ok, page_free, sw_ok, sw_lost;

   always_comb begin
      rel_ok    = rd_release && !rx_clear && (count != '0);
      cnt_rel   = count - {{PW{1'b0}}, rel_ok};
      page_free = cnt_rel < CNT_FULL;
      sw_ok     = switch && !rx_clear && page_free;
      sw_lost   = switch && !rx_clear && !page_free;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rx_abort <= 1'b0;
      end else begin
         rx_abort <= rx_clear;
         if (rx_clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, rel_ok};
            wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, sw_ok};
            count  <= cnt_rel + {{PW{1'b0}}, sw_ok};
         end
      end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         lost_cnt <= '0;
         err_cnt  <= '0;
      end else if (cnt_clr) begin
         lost_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (sw_lost && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
         if (rx_error && err_cnt != 8'hFF) err_cnt  <= err_cnt + 8'd1;
      end

   for (genvar i = 0; i < PAGES; i++) begin : g_slot
      rx_page_slot u_slot (
         .clk     (clk),
         .reset_n (reset_n),
         .we      (sw_ok && (wr_ptr == PW'(i))),
         .d       (wr_flags),
         .q       (flags[i])
      );
   end

   assign wr_page  = wr_ptr;
   assign rd_page  = rd_ptr;
   assign pend_cnt = count;
   assign rx_pend  = (count != '0);
   assign rd_flags = flags[rd_ptr];
endmodule

// File: tb/tb_rx_page_ctrl.sv
// Directed bench for rx_page_ctrl with PAGES=4; expected values hand-computed.

module tb_rx_page_ctrl;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       switch, rx_error, rd_release, rx_clear, cnt_clr;
   logic [7:0] wr_flags;
   logic       rx_abort, rx_pend;
   logic [1:0] wr_page, rd_page;
   logic [7:0] rd_flags, lost_cnt, err_cnt;
   logic [2:0] pend_cnt;

   int ncmp = 0;
   int nfail = 0;

   rx_page_ctrl #(.PAGES(4)) dut (
      .clk(clk), .reset_n(reset_n), .switch(switch), .wr_flags(wr_flags),
      .rx_error(rx_error), .rx_abort(rx_abort), .wr_page(wr_page),
      .rx_pend(rx_pend), .rd_page(rd_page), .rd_flags(rd_flags),
      .rd_release(rd_release), .rx_clear(rx_clear), .pend_cnt(pend_cnt),
      .lost_cnt(lost_cnt), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      switch = 0; rx_error = 0; rd_release = 0; rx_clear = 0; cnt_clr = 0; wr_flags = 0;
   endtask

   task automatic chk_q(input string tag, input logic [1:0] wp, input logic [1:0] rp,
                        input logic [2:0] pc, input logic [7:0] rf);
      chk({tag, ".wr_page"},  32'(wr_page),  32'(wp));
      chk({tag, ".rd_page"},  32'(rd_page),  32'(rp));
      chk({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(pc));
      chk({tag, ".rx_pend"},  32'(rx_pend),  32'(pc != 0));
      chk({tag, ".rd_flags"}, 32'(rd_flags), 32'(rf));
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      #2;
      chk_q("reset", 2'd0, 2'd0, 3'd0, 8'h00);
      chk("reset.lost", 32'(lost_cnt), 0);
      chk("reset.err",  32'(err_cnt), 0);
      chk("reset.abort", 32'(rx_abort), 0);
      cyc();
      reset_n = 1'b1;

      // Three frames fill the queue.
      switch = 1; wr_flags = 8'h00; cyc();
      chk_q("sw1", 2'd1, 2'd0, 3'd1, 8'h00);
      wr_flags = 8'h12; cyc();
      chk_q("sw2", 2'd2, 2'd0, 3'd2, 8'h00);
      wr_flags = 8'h00; cyc();
      chk_q("sw3", 2'd3, 2'd0, 3'd3, 8'h00);

      // Overflow: frame lost, page reused.
      wr_flags = 8'h55; cyc();
      chk_q("ovf", 2'd3, 2'd0, 3'd3, 8'h00);
      chk("ovf.lost", 32'(lost_cnt), 1);

      // Release + switch on full queue: accepted, wr_page wraps 3->0.
      rd_release = 1; wr_flags = 8'h34; cyc();
      chk_q("relsw", 2'd0, 2'd1, 3'd3, 8'h12);
      chk("relsw.lost", 32'(lost_cnt), 1);

      idle(); rd_release = 1; cyc();
      chk_q("rel1", 2'd0, 2'd2, 3'd2, 8'h00);
      cyc();
      chk_q("rel2", 2'd0, 2'd3, 3'd1, 8'h34);

      idle(); switch = 1; wr_flags = 8'h77; cyc();
      chk_q("sw4", 2'd1, 2'd3, 3'd2, 8'h34);
      wr_flags = 8'h01; cyc();
      chk_q("sw5", 2'd2, 2'd3, 3'd3, 8'h34);

      // 300 overflowed frames: lost_cnt 1 -> saturates at 255.
      wr_flags = 8'hEE;
      repeat (253) cyc();
      chk("lost.254", 32'(lost_cnt), 254);
      cyc();
      chk("lost.255", 32'(lost_cnt), 255);
      repeat (46) cyc();
      chk("lost.sat", 32'(lost_cnt), 255);
      chk_q("lost.q", 2'd2, 2'd3, 3'd3, 8'h34);

      // Clear beats same-cycle increments.
      rx_error = 1; cnt_clr = 1; cyc();
      chk("clr.lost", 32'(lost_cnt), 0);
      chk("clr.err",  32'(err_cnt), 0);
      idle(); rx_error = 1; cyc(); cyc();
      chk("err.2", 32'(err_cnt), 2);

      idle(); rd_release = 1; cyc();
      chk_q("rel3", 2'd2, 2'd0, 3'd2, 8'h77);

      // Flush with a coincident switch: switch ignored, no loss counted.
      idle(); rx_clear = 1; switch = 1; wr_flags = 8'h99; cyc();
      chk_q("flush", 2'd2, 2'd2, 3'd0, 8'h00);
      chk("flush.abort", 32'(rx_abort), 1);
      chk("flush.lost", 32'(lost_cnt), 0);
      idle(); cyc();
      chk("flush.abort_end", 32'(rx_abort), 0);

      rx_clear = 1; cyc();
      chk("hold.abort1", 32'(rx_abort), 1);
      cyc();
      chk("hold.abort2", 32'(rx_abort), 1);
      idle(); cyc();
      chk("hold.abort_end", 32'(rx_abort), 0);

      rd_release = 1; cyc();
      chk_q("rel_empty", 2'd2, 2'd2, 3'd0, 8'h00);

      idle(); switch = 1; wr_flags = 8'hAB; cyc();
      idle();
      chk_q("sw6", 2'd3, 2'd2, 3'd1, 8'hAB);

      // Asynchronous reset between clock edges.
      #2 reset_n = 1'b0;
      #1;
      chk_q("areset", 2'd0, 2'd0, 3'd0, 8'h00);
      chk("areset.err", 32'(err_cnt), 0);
      chk("areset.abort", 32'(rx_abort), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
